// File: rtl/spi_burst_capture.sv
// Captures a burst of words strobed in from an asynchronous SPI-side source,
// tagging each with a sequential address and reporting burst completion/abort.
module spi_burst_capture #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] burst_count,
  input  logic [ADDR_WIDTH-1:0]  start_address,
  input  logic                   burst_data_enable,
  input  logic [DATA_WIDTH-1:0]  burst_data,
  output logic                   busy,
  output logic                   data_valid,
  output logic [ADDR_WIDTH-1:0]  memory_address,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   done,
  output logic                   aborted,
  output logic [COUNT_WIDTH-1:0] capture_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   strobe_edge;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0]  next_addr;

  // Synchroniser and history flop run in every state so an edge that began
  // outside S_CAPTURE is consumed there and never replayed later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], burst_data_enable};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      data_valid     <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      data           <= '0;
      memory_address <= '0;
      capture_count  <= '0;
      remaining      <= '0;
      next_addr      <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            aborted       <= 1'b0;
            capture_count <= '0;
            if (burst_count != '0) begin
              remaining <= burst_count;
              next_addr <= start_address;
              busy      <= 1'b1;
              state     <= S_CAPTURE;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (strobe_edge) begin
            data           <= burst_data;
            memory_address <= next_addr;
            data_valid     <= 1'b1;
            next_addr      <= next_addr + ADDR_WIDTH'(1);
            remaining      <= remaining - COUNT_WIDTH'(1);
            capture_count  <= capture_count + COUNT_WIDTH'(1);
            if (remaining == COUNT_WIDTH'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_capture.sv
// Randomised bench for spi_burst_capture: expected captures are built from the
// burst rules (address = start + index mod 2^16, data = word sent) and compared.
module tb_spi_burst_capture;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] burst_count = '0;
  logic [15:0] start_address = '0;
  logic        bde = 1'b0;
  logic [15:0] burst_data = '0;

  logic        busy, data_valid, done, aborted;
  logic [15:0] memory_address, data, capture_count;
  logic        busy3, v3, done3, aborted3;
  logic [15:0] addr3, data3, count3;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q[$];
  int done_cnt = 0;
  bit busy_seen = 0;

  spi_burst_capture dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .abort(abort),
    .burst_count(burst_count), .start_address(start_address),
    .burst_data_enable(bde), .burst_data(burst_data),
    .busy(busy), .data_valid(data_valid), .memory_address(memory_address),
    .data(data), .done(done), .aborted(aborted), .capture_count(capture_count)
  );

  spi_burst_capture #(.SYNC_STAGES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .abort(abort),
    .burst_count(burst_count), .start_address(start_address),
    .burst_data_enable(bde), .burst_data(burst_data),
    .busy(busy3), .data_valid(v3), .memory_address(addr3),
    .data(data3), .done(done3), .aborted(aborted3), .capture_count(count3)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (data_valid === 1'b1) got_q.push_back({memory_address, data});
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_seen = 1;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_word(input logic [15:0] d, input int hi, input int lo);
    burst_data = d;
    bde = 1'b1;
    step(hi);
    bde = 1'b0;
    step(lo);
  endtask

  task automatic start_burst(input logic [15:0] cnt, input logic [15:0] addr);
    burst_count = cnt;
    start_address = addr;
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 60 && done_cnt <= base; i++) step();
    checks++;
    if (done_cnt <= base) begin
      errors++;
      $display("FAIL wait_done: done pulses %0d, required more than %0d", done_cnt, base);
    end
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", data_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b exp 0", aborted); end
    checks++; if ({data, memory_address, capture_count} !== 48'h0) begin
      errors++; $display("FAIL reset_regs: got %h exp 0", {data, memory_address, capture_count});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_q[$];
    logic [15:0] d;
    int base;
    got_q.delete();
    base = done_cnt;
    start_burst(16'd4, 16'h0100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
    for (int i = 0; i < 4; i++) begin
      d = 16'h00A1 + 16'(i);
      exp_q.push_back({16'h0100 + 16'(i), d});
      send_word(d, int'($urandom_range(1, 3)), 3);
    end
    wait_done(base);
    step(2);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_nwords: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_word%0d: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (capture_count !== 16'd4) begin errors++; $display("FAIL basic_count: got %0d exp 4", capture_count); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted: got %b exp 0", aborted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b exp 0", busy); end
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL basic_done: got %0d pulses exp 1", done_cnt - base); end
  endtask

  // Consecutive random bursts, each started on the first idle cycle after done.
  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [15:0] d, a, n;
    int base;
    for (int b = 0; b < 5; b++) begin
      exp_q.delete();
      got_q.delete();
      base = done_cnt;
      n = 16'($urandom_range(1, 6));
      a = (b == 4) ? 16'hFFFE : 16'($urandom);
      if (b == 4) n = 16'd3;
      start_burst(n, a);
      for (int i = 0; i < int'(n); i++) begin
        d = 16'($urandom);
        exp_q.push_back({16'(a + 16'(i)), d});
        send_word(d, int'($urandom_range(1, 3)), int'($urandom_range(3, 4)));
      end
      wait_done(base);
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL b2b%0d_nwords: got %0d exp %0d", b, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b%0d_word%0d: got %h exp %h", b, i, got_q[i], exp_q[i]);
        end
      end
      checks++; if (capture_count !== n) begin errors++; $display("FAIL b2b%0d_count: got %0d exp %0d", b, capture_count, n); end
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL b2b%0d_done: got %0d pulses exp 1", b, done_cnt - base); end
    end
  endtask

  task automatic test_zero_count();
    int base;
    got_q.delete();
    base = done_cnt;
    busy_seen = 0;
    start_burst(16'd0, 16'($urandom));
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_hi: got %b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b exp 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_lo: got %b exp 0", done); end
    step(3);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_nwords: got %0d exp 0", got_q.size()); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_busy_seen: got %0d exp 0", busy_seen); end
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL zero_pulses: got %0d exp 1", done_cnt - base); end
    checks++; if (capture_count !== 16'd0) begin errors++; $display("FAIL zero_count: got %0d exp 0", capture_count); end
  endtask

  task automatic test_preheld_strobe();
    logic [15:0] a, d;
    int base;
    got_q.delete();
    base = done_cnt;
    a = 16'($urandom);
    burst_data = 16'($urandom);
    bde = 1'b1;
    step(5);
    start_burst(16'd1, a);
    step(5);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL preheld_nocap: got %0d words exp 0", got_q.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL preheld_busy: got %b exp 1", busy); end
    bde = 1'b0;
    step(3);
    d = 16'($urandom);
    send_word(d, 2, 3);
    wait_done(base);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL preheld_nwords: got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== {a, d}) begin errors++; $display("FAIL preheld_word: got %h exp %h", got_q[0], {a, d}); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] exp_q[$];
    logic [15:0] a, d;
    int base;
    got_q.delete();
    base = done_cnt;
    a = 16'($urandom);
    start_burst(16'd5, a);
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      exp_q.push_back({16'(a + 16'(i)), d});
      send_word(d, int'($urandom_range(1, 3)), 3);
    end
    // Third strobe: its edge reaches the two-stage sync output two edges later.
    burst_data = 16'($urandom);
    bde = 1'b1;
    step(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    bde = 1'b0;
    step(3);
    wait_done(base);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL abort_nwords: got %0d exp 2", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_word%0d: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (capture_count !== 16'd2) begin errors++; $display("FAIL abort_count: got %0d exp 2", capture_count); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b exp 1", aborted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL abort_done: got %0d pulses exp 1", done_cnt - base); end
    send_word(16'($urandom), 2, 4);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL idle_strobe: got %0d words exp 2", got_q.size()); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_hold: got %b exp 1", aborted); end
  endtask

  task automatic test_latency();
    int pulses;
    pulses = 0;
    pulse_reset();
    start_burst(16'd2, 16'h0200);
    burst_data = 16'h5A5A;
    bde = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (v3 === 1'b1) pulses++;
      checks++; if (v3 !== (k == 4)) begin
        errors++; $display("FAIL latency_k%0d: data_valid got %b exp %b", k, v3, (k == 4));
      end
      if (k == 4) begin
        checks++; if ({addr3, data3} !== {16'h0200, 16'h5A5A}) begin
          errors++; $display("FAIL latency_word: got %h exp 02005a5a", {addr3, data3});
        end
      end
      if (k == 10) bde = 1'b0;
    end
    checks++; if (pulses != 1 || count3 !== 16'd1) begin
      errors++; $display("FAIL latency_once: got %0d pulses count %0d exp 1/1", pulses, count3);
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] exp_q[$];
    logic [15:0] a, d;
    int base;
    a = 16'($urandom);
    start_burst(16'd4, a);
    send_word(16'h1234, 2, 3);
    send_word(16'hBEEF, 2, 3);
    checks++; if (capture_count !== 16'd2) begin errors++; $display("FAIL midrst_pre: got %0d exp 2", capture_count); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, data_valid, done, aborted} !== 4'b0) begin
      errors++; $display("FAIL midrst_flags: got %b exp 0000", {busy, data_valid, done, aborted});
    end
    checks++; if ({data, memory_address, capture_count} !== 48'h0) begin
      errors++; $display("FAIL midrst_regs: got %h exp 0", {data, memory_address, capture_count});
    end
    step(2);
    reset_n = 1'b1;
    got_q.delete();
    base = done_cnt;
    a = 16'($urandom);
    start_burst(16'd3, a);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_restart: busy got %b exp 1", busy); end
    checks++; if (done_cnt != base || capture_count !== 16'd0) begin
      errors++; $display("FAIL midrst_clean: done pulses %0d count %0d exp 0/0", done_cnt - base, capture_count);
    end
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      exp_q.push_back({16'(a + 16'(i)), d});
      send_word(d, 1, 3);
    end
    wait_done(base);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL midrst_nwords: got %0d exp 3", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_word%0d: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_count();
    test_preheld_strobe();
    test_abort();
    test_latency();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
